// File: rtl/df_pe_sequencer.sv
// Sequencer for one multiply/quantise/accumulate PE: clears it, streams LEN
// x/w pairs out of the two buffers, and samples the result at the fixed-latency point.
module df_pe_sequencer #(
  parameter int LEN    = 9,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_x_base,
  input  logic [ADDR_W-1:0]  cmd_w_base,
  output logic               x_rd_en,
  output logic [ADDR_W-1:0]  x_addr,
  input  logic signed [15:0] x_rdata,
  output logic               w_rd_en,
  output logic [ADDR_W-1:0]  w_addr,
  input  logic signed [15:0] w_rdata,
  output logic               pe_clr,
  output logic               pe_start,
  output logic signed [15:0] pe_x,
  output logic signed [15:0] pe_w,
  input  logic signed [15:0] pe_odata,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [15:0] res_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX   = 8'(LEN - 1);
  localparam logic [7:0] DRAIN_LAST = 8'd2;

  state_t              r_state;
  state_t              w_nxt_state;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic [ADDR_W-1:0]   r_x_base;
  logic [ADDR_W-1:0]   r_w_base;
  logic                r_pe_start;
  logic                r_res_valid;
  logic signed [15:0]  r_res_data;

  logic                w_accept;
  logic                w_rd;
  logic                w_clr;
  logic                w_capture;
  logic                w_release;
  logic [ADDR_W-1:0]   w_x_addr;
  logic [ADDR_W-1:0]   w_w_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_rd        = 1'b0;
    w_clr       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_nxt_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_clr       = 1'b1;
        w_cnt_nxt   = '0;
        w_nxt_state = S_STREAM;
      end
      S_STREAM: begin
        w_rd = 1'b1;
        if (r_cnt == LAST_IDX) begin
          w_cnt_nxt   = '0;
          w_nxt_state = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_DRAIN: begin
        // the PE keeps re-adding its last term, so this edge must be exact
        if (r_cnt == DRAIN_LAST) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = '0;
          w_nxt_state = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (r_res_valid && res_ready) begin
          w_release   = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_base    <= '0;
      r_w_base    <= '0;
      r_pe_start  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      if (w_accept) begin
        r_x_base <= cmd_x_base;
        r_w_base <= cmd_w_base;
      end
      r_pe_start <= w_rd;
      if (w_capture) begin
        r_res_data  <= pe_odata;
        r_res_valid <= 1'b1;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign w_x_addr = r_x_base + ADDR_W'(r_cnt);
  assign w_w_addr = r_w_base + ADDR_W'(r_cnt);

  assign cmd_ready = (r_state == S_IDLE);
  assign x_rd_en   = w_rd;
  assign w_rd_en   = w_rd;
  assign x_addr    = w_rd ? w_x_addr : '0;
  assign w_addr    = w_rd ? w_w_addr : '0;
  assign pe_clr    = w_clr;
  assign pe_start  = r_pe_start;
  // operands only mean something under pe_start; gating keeps them 0 otherwise
  assign pe_x      = r_pe_start ? x_rdata : '0;
  assign pe_w      = r_pe_start ? w_rdata : '0;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_df_pe_sequencer.sv
// Directed bench: two sequencers (LEN=4, LEN=1), each with buffer and PE models.
module tb_df_pe_sequencer;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic               cmd_valid  [2];
  logic               cmd_ready  [2];
  logic [7:0]         cmd_x_base [2];
  logic [7:0]         cmd_w_base [2];
  logic               x_rd_en    [2];
  logic [7:0]         x_addr     [2];
  logic signed [15:0] x_rdata    [2];
  logic               w_rd_en    [2];
  logic [7:0]         w_addr     [2];
  logic signed [15:0] w_rdata    [2];
  logic               pe_clr     [2];
  logic               pe_start   [2];
  logic signed [15:0] pe_x       [2];
  logic signed [15:0] pe_w       [2];
  logic signed [15:0] acc        [2];
  logic signed [15:0] term       [2];
  logic               run        [2];
  logic               res_valid  [2];
  logic               res_ready  [2];
  logic signed [15:0] res_data   [2];
  logic signed [15:0] xmem [2][256];
  logic signed [15:0] wmem [2][256];
  int                 clr_cnt [2];
  int                 rd_cnt  [2];

  df_pe_sequencer #(.LEN(4), .ADDR_W(8)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_x_base(cmd_x_base[0]), .cmd_w_base(cmd_w_base[0]),
    .x_rd_en(x_rd_en[0]), .x_addr(x_addr[0]), .x_rdata(x_rdata[0]),
    .w_rd_en(w_rd_en[0]), .w_addr(w_addr[0]), .w_rdata(w_rdata[0]),
    .pe_clr(pe_clr[0]), .pe_start(pe_start[0]), .pe_x(pe_x[0]), .pe_w(pe_w[0]),
    .pe_odata(acc[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_data(res_data[0])
  );

  df_pe_sequencer #(.LEN(1), .ADDR_W(8)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_x_base(cmd_x_base[1]), .cmd_w_base(cmd_w_base[1]),
    .x_rd_en(x_rd_en[1]), .x_addr(x_addr[1]), .x_rdata(x_rdata[1]),
    .w_rd_en(w_rd_en[1]), .w_addr(w_addr[1]), .w_rdata(w_rdata[1]),
    .pe_clr(pe_clr[1]), .pe_start(pe_start[1]), .pe_x(pe_x[1]), .pe_w(pe_w[1]),
    .pe_odata(acc[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_data(res_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [15:0] quant(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    int t;
    t = (int'(a) * int'(b)) / 1000;
    return t[15:0];
  endfunction

  // Buffers with one-cycle read latency; PE registers the quantised term and
  // then adds it into acc every cycle after its first start.
  for (genvar g = 0; g < 2; g++) begin : g_env
    always @(posedge clk) begin
      if (x_rd_en[g]) x_rdata[g] <= xmem[g][x_addr[g]];
      if (w_rd_en[g]) w_rdata[g] <= wmem[g][w_addr[g]];
      if (x_rd_en[g] || w_rd_en[g]) rd_cnt[g] <= rd_cnt[g] + 1;
      if (pe_clr[g]) begin
        clr_cnt[g] <= clr_cnt[g] + 1;
        acc[g]     <= '0;
        term[g]    <= '0;
        run[g]     <= 1'b0;
      end else begin
        if (pe_start[g]) begin
          term[g] <= quant(pe_x[g], pe_w[g]);
          run[g]  <= 1'b1;
        end
        if (run[g]) acc[g] <= acc[g] + term[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic run_job(input int k, input logic [7:0] xb, input logic [7:0] wb,
                         output logic signed [15:0] res, output int lat);
    cmd_x_base[k] = xb;
    cmd_w_base[k] = wb;
    cmd_valid[k]  = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      cmd_valid[k] = 1'b0;
    end while (res_valid[k] !== 1'b1 && lat < 60);
    res = res_data[k];
  endtask

  task automatic release_res(input int k);
    res_ready[k] = 1'b1;
    tick();
    res_ready[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [15:0] r;
    int lat, c0, rd0, viol;
    int wrap_x [4];
    int wrap_w [4];

    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) begin
        xmem[k][a] = '0;
        wmem[k][a] = '0;
      end
      cmd_valid[k] = 1'b0; cmd_x_base[k] = '0; cmd_w_base[k] = '0;
      res_ready[k] = 1'b0; clr_cnt[k] = 0; rd_cnt[k] = 0;
    end
    xmem[0][0] = 16'sd1000;  wmem[0][0] = 16'sd2;
    xmem[0][1] = 16'sd2000;  wmem[0][1] = 16'sd3;
    xmem[0][2] = -16'sd3000; wmem[0][2] = 16'sd4;
    xmem[0][3] = 16'sd500;   wmem[0][3] = 16'sd1000;
    xmem[0][16] = 16'sd1000; wmem[0][16] = 16'sd7;
    xmem[1][0] = -16'sd1500; wmem[1][0] = 16'sd1;
    xmem[1][1] = 16'sd999;   wmem[1][1] = 16'sd1;

    rst = 1'b0;
    #12;
    chk("rst_cmd_ready", cmd_ready[0], 1);
    chk("rst_rd_en", x_rd_en[0], 0);
    chk("rst_pe_clr", pe_clr[0], 0);
    chk("rst_pe_start", pe_start[0], 0);
    chk("rst_res_valid", res_valid[0], 0);
    chk("rst_res_data", res_data[0], 0);
    chk("rst_x_addr", x_addr[0], 0);
    rst = 1'b1;
    tick();

    // basic dot product and latency
    c0 = clr_cnt[0];
    run_job(0, 8'd0, 8'd0, r, lat);
    chk("a_result", r, 496);
    chk("a_latency", lat, 9);
    release_res(0);
    chk("a_released", res_valid[0], 0);
    chk("a_cmd_ready", cmd_ready[0], 1);

    // back-to-back: must not carry over the previous sum
    run_job(0, 8'd16, 8'd16, r, lat);
    chk("b_result", r, 7);
    chk("b_latency", lat, 9);
    chk("clr_per_job", clr_cnt[0] - c0, 2);
    release_res(0);

    // truncation toward zero, then a cleared accumulator
    run_job(1, 8'd0, 8'd0, r, lat);
    chk("t_neg_result", r, -1);
    chk("t_latency", lat, 6);
    release_res(1);
    run_job(1, 8'd1, 8'd1, r, lat);
    chk("t_zero_result", r, 0);
    release_res(1);

    // backpressure in HOLD
    run_job(0, 8'd0, 8'd0, r, lat);
    chk("bp_result", r, 496);
    rd0 = rd_cnt[0];
    c0  = clr_cnt[0];
    viol = 0;
    cmd_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid[0] !== 1'b1 || res_data[0] !== 16'sd496 || cmd_ready[0] !== 1'b0)
        viol++;
    end
    cmd_valid[0] = 1'b0;
    chk("bp_stable", viol, 0);
    chk("bp_no_reads", rd_cnt[0] - rd0, 0);
    chk("bp_no_clr", clr_cnt[0] - c0, 0);
    release_res(0);
    chk("bp_released", res_valid[0], 0);

    // address wrap
    cmd_x_base[0] = 8'd254;
    cmd_w_base[0] = 8'd100;
    cmd_valid[0]  = 1'b1;
    tick();
    cmd_valid[0]  = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      wrap_x[i] = int'(x_addr[0]);
      wrap_w[i] = int'(w_addr[0]);
      chk("wrap_rd_en", x_rd_en[0], 1);
      tick();
    end
    chk("wrap_x0", wrap_x[0], 254);
    chk("wrap_x1", wrap_x[1], 255);
    chk("wrap_x2", wrap_x[2], 0);
    chk("wrap_x3", wrap_x[3], 1);
    chk("wrap_w3", wrap_w[3], 103);
    chk("wrap_rd_done", x_rd_en[0], 0);
    lat = 0;
    while (res_valid[0] !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    chk("wrap_wait", lat, 3);
    chk("wrap_result", res_data[0], 0);
    release_res(0);

    // reset in the middle of STREAM
    cmd_x_base[0] = 8'd0;
    cmd_w_base[0] = 8'd0;
    cmd_valid[0]  = 1'b1;
    tick();
    cmd_valid[0]  = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_x_addr_i2", x_addr[0], 2);
    chk("mid_pe_start", pe_start[0], 1);
    rst = 1'b0;
    #1;
    chk("mid_cmd_ready", cmd_ready[0], 1);
    chk("mid_rd_en", x_rd_en[0], 0);
    chk("mid_x_addr", x_addr[0], 0);
    chk("mid_pe_start_rst", pe_start[0], 0);
    chk("mid_pe_x", pe_x[0], 0);
    chk("mid_res_valid", res_valid[0], 0);
    #2;
    rst = 1'b1;
    tick();
    run_job(0, 8'd0, 8'd0, r, lat);
    chk("mid_recover_result", r, 496);
    chk("mid_recover_latency", lat, 9);
    release_res(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
